// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency registered multiplier among NREQ requesters.
// Optional issue/busy statistics counters are built when MUL_ARB_STATS_EN is defined.
module mul_share_arbiter #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*N-1:0]  opA,
  input  logic [NREQ*N-1:0]  opB,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [2*N-1:0]     rsp_result,
  output logic               rsp_overflow,
  output logic               idle,
  output logic               mul_en,
  output logic [N-1:0]       mul_a,
  output logic [N-1:0]       mul_b,
  input  logic [2*N-1:0]     mul_result,
  input  logic               mul_overflow
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [31:0]        issue_count,
  output logic [31:0]        busy_count
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] eligible;
  logic            grant_any;
  logic [PW-1:0]   grant_id;
  logic [PW:0]     scan;
  logic            tag_v  [LAT];
  logic [PW-1:0]   tag_id [LAT];

  // Round-robin search from ptr upward, wrapping at NREQ.
  always_comb begin
    eligible  = req & ~pending;
    gnt       = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    scan      = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan = {1'b0, ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(NREQ)) begin
        scan = scan - (PW+1)'(NREQ);
      end
      if (!reset && !grant_any && eligible[scan[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = scan[PW-1:0];
      end
    end
    if (grant_any) begin
      gnt[grant_id] = 1'b1;
    end
  end

  // Operand mux toward the multiplier; zero when nothing is issued.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        mul_a = opA[i*N +: N];
        mul_b = opB[i*N +: N];
      end
    end
  end

  assign mul_en = ~reset;
  assign idle   = ~reset & ~(|pending) & ~(|req);

  // Tag at the end of the pipe steers the multiplier output back to its issuer.
  always_comb begin
    rsp_valid    = '0;
    rsp_result   = '0;
    rsp_overflow = 1'b0;
    if (!reset && tag_v[LAT-1]) begin
      rsp_valid[tag_id[LAT-1]] = 1'b1;
      rsp_result               = mul_result;
      rsp_overflow             = mul_overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      pending <= '0;
      for (int s = 0; s < int'(LAT); s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
    end else begin
      pending <= (pending & ~rsp_valid) | gnt;
      if (grant_any) begin
        ptr <= (grant_id == PW'(NREQ - 1)) ? '0 : grant_id + PW'(1);
      end
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_id;
      for (int s = 1; s < int'(LAT); s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

`ifdef MUL_ARB_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_count <= '0;
      busy_count  <= '0;
    end else begin
      if (grant_any && issue_count != 32'hFFFF_FFFF) begin
        issue_count <= issue_count + 32'd1;
      end
      if ((|pending) && busy_count != 32'hFFFF_FFFF) begin
        busy_count <= busy_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with a 2-stage registered multiplier model.
module tb_mul_share_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] opA, opB;
  logic [3:0]   gnt, rsp_valid;
  logic [63:0]  rsp_result;
  logic         rsp_overflow, idle, mul_en;
  logic [31:0]  mul_a, mul_b;
  logic [63:0]  mul_result;
  logic         mul_overflow;

  logic [31:0]  ra, rb;
  logic [63:0]  prod;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          id;
    logic [63:0] res;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] exp_prod [4];
  logic        exp_ovf  [4];

  mul_share_arbiter #(.N(32), .NREQ(4), .LAT(2)) dut (
    .clk(clk), .reset(reset), .req(req), .opA(opA), .opB(opB),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .idle(idle), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .mul_overflow(mul_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier wrapper model: operand regs then result regs.
  always @(posedge clk) begin
    if (mul_en) begin
      ra   <= mul_a;
      rb   <= mul_b;
      prod <= 64'(ra) * 64'(rb);
    end
  end
  assign mul_result   = prod;
  assign mul_overflow = |prod[63:32];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p, input logic o);
    opA[i*32 +: 32] = a;
    opB[i*32 +: 32] = b;
    exp_prod[i]     = p;
    exp_ovf[i]      = o;
  endtask

  task automatic push_exp(input logic [3:0] eg);
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) sb.push_back('{i, exp_prod[i], exp_ovf[i], cyc + 2});
    end
  endtask

  // One cycle: check gnt, queue the expected response, optionally drop granted reqs.
  task automatic step(input logic [3:0] eg, input bit drop, input string nm);
    logic [3:0] g;
    @(negedge clk);
    chk(nm, 64'(gnt), 64'(eg));
    if (eg != 4'b0) push_exp(eg);
    g = gnt;
    @(posedge clk); #1;
    if (drop) req = req & ~g;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: any due expectation must appear now; otherwise outputs stay quiet.
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1) << mon_e.id);
        chk("rsp_result", rsp_result, mon_e.res);
        chk("rsp_overflow", 64'(rsp_overflow), 64'(mon_e.ovf));
      end else if (rsp_valid != 4'b0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else if (rsp_result != 64'b0 || rsp_overflow != 1'b0) begin
        chk("quiet_rsp_data", {rsp_result[62:0], rsp_overflow}, 64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req   = 4'b0;
    opA   = '0;
    opB   = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 4'b0100;
    opA[64 +: 32] = 32'd9;
    @(negedge clk);
    chk("reset_gnt", 64'(gnt), 64'(0));
    chk("reset_mul_en", 64'(mul_en), 64'(0));
    chk("reset_mul_a", 64'(mul_a), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_idle", 64'(idle), 64'(0));
    @(posedge clk); #1;
    req   = 4'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 64'(idle), 64'(1));
    @(posedge clk); #1;

    // Single request on requester 2: 6*7
    set_ops(2, 32'd6, 32'd7, 64'd42, 1'b0);
    req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", 64'(gnt), 64'(4'b0100));
    chk("single_mul_a", 64'(mul_a), 64'(6));
    chk("single_mul_b", 64'(mul_b), 64'(7));
    chk("single_mul_en", 64'(mul_en), 64'(1));
    chk("single_idle_busy", 64'(idle), 64'(0));
    push_exp(4'b0100);
    @(posedge clk); #1;
    req = 4'b0;
    step(4'b0000, 1'b0, "single_t1");
    step(4'b0000, 1'b0, "single_t2");
    @(negedge clk);
    chk("single_idle_t3", 64'(idle), 64'(1));
    @(posedge clk); #1;

    // All four request with ptr=0
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 32'(i + 1), 32'd10, 64'(10 * (i + 1)), 1'b0);
    req = 4'b1111;
    step(4'b0001, 1'b1, "all_gnt0");
    step(4'b0010, 1'b1, "all_gnt1");
    step(4'b0100, 1'b1, "all_gnt2");
    step(4'b1000, 1'b1, "all_gnt3");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "all_drain");

    // Requester 1 holds req: grants only every LAT+1 cycles
    set_ops(1, 32'd3, 32'd5, 64'd15, 1'b0);
    req = 4'b0010;
    step(4'b0010, 1'b0, "hold_gnt_t0");
    step(4'b0000, 1'b0, "hold_mask_t1");
    step(4'b0000, 1'b0, "hold_mask_t2");
    step(4'b0010, 1'b0, "hold_gnt_t3");
    step(4'b0000, 1'b0, "hold_mask_t4");
    step(4'b0000, 1'b0, "hold_mask_t5");
    step(4'b0010, 1'b1, "hold_gnt_t6");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "hold_drain");

    // Move ptr to 3, then wrap 3 -> 0 and confirm ptr lands on 1
    set_ops(2, 32'd2, 32'd3, 64'd6, 1'b0);
    req = 4'b0100;
    step(4'b0100, 1'b1, "wrap_setup");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "wrap_setup_drain");
    set_ops(3, 32'd2, 32'd9, 64'd18, 1'b0);
    set_ops(0, 32'd4, 32'd4, 64'd16, 1'b0);
    req = 4'b1001;
    step(4'b1000, 1'b1, "wrap_gnt3");
    step(4'b0001, 1'b1, "wrap_gnt0");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "wrap_drain");
    set_ops(0, 32'd5, 32'd5, 64'd25, 1'b0);
    set_ops(1, 32'd7, 32'd8, 64'd56, 1'b0);
    req = 4'b0011;
    step(4'b0010, 1'b1, "ptr1_gnt1");
    step(4'b0001, 1'b1, "ptr1_gnt0");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "ptr1_drain");

    // Reset one cycle after a grant: the result must never appear
    set_ops(0, 32'd11, 32'd11, 64'd121, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    chk("rst_mid_gnt", 64'(gnt), 64'(4'b0001));
    @(posedge clk); #1;
    reset = 1'b1;
    req   = 4'b0100;
    @(negedge clk);
    chk("rst_mid_gnt_during", 64'(gnt), 64'(0));
    chk("rst_mid_mul_en", 64'(mul_en), 64'(0));
    chk("rst_mid_rsp", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    req   = 4'b0;
    @(negedge clk);
    chk("rst_mid_no_rsp", 64'(rsp_valid), 64'(0));
    chk("rst_mid_idle", 64'(idle), 64'(1));
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) step(4'b0000, 1'b0, "rst_mid_drain");

    // Widest operands
    set_ops(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    req = 4'b0001;
    step(4'b0001, 1'b1, "wide_gnt");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "wide_drain");

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
